// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with pixel-clock enable,
// configurable sync polarity and a sync/blank delay line for fetch-pipeline alignment.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter bit          H_POL      = 1'b0,
  parameter bit          V_POL      = 1'b0,
  parameter int unsigned CW         = 10,
  parameter int unsigned SYNC_DELAY = 2,
  parameter int unsigned FCW        = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           pix_en,
  output logic [CW-1:0]  x,
  output logic [CW-1:0]  y,
  output logic           hs,
  output logic           vs,
  output logic           de,
  output logic           line_start,
  output logic           frame_start,
  output logic [FCW-1:0] frame_cnt
);

  localparam int unsigned H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;
  localparam longint unsigned CW_MAX   = (64'd1 << CW) - 64'd1;

  // Elaboration-time rejection of unsupported geometry
  if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_geom
    $error("vga_timing_gen: active, porch and sync widths must all be non-zero");
  end
  if (CW == 0 || CW > 31 || longint'(H_TOTAL - 1) > CW_MAX ||
      longint'(V_TOTAL - 1) > CW_MAX) begin : g_bad_cw
    $error("vga_timing_gen: CW too small for H_TOTAL-1 / V_TOTAL-1");
  end
  if (FCW == 0 || FCW > 31) begin : g_bad_fcw
    $error("vga_timing_gen: FCW out of range");
  end

  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
    logic ls;
    logic fs;
  } sync_t;

  localparam sync_t SYNC_IDLE = '{hs: ~H_POL, vs: ~V_POL, de: 1'b0, ls: 1'b0, fs: 1'b0};

  logic [CW-1:0]  h_q, h_d;
  logic [CW-1:0]  v_q, v_d;
  logic [FCW-1:0] fcnt_q, fcnt_d;
  logic [CW-1:0]  x_q, y_q;
  sync_t          st0_d;
  sync_t          pipe_q [SYNC_DELAY+1];
  logic           h_last, v_last, hs_on, vs_on;

  // Raster counters; frame_cnt steps on the frame wrap edge itself
  always_comb begin
    h_d    = h_q;
    v_d    = v_q;
    fcnt_d = fcnt_q;
    h_last = (h_q == CW'(H_TOTAL - 1));
    v_last = (v_q == CW'(V_TOTAL - 1));
    if (h_last) begin
      h_d = '0;
      if (v_last) begin
        v_d    = '0;
        fcnt_d = fcnt_q + FCW'(1);
      end else begin
        v_d = v_q + CW'(1);
      end
    end else begin
      h_d = h_q + CW'(1);
    end
  end

  // Stage-0 decode of the current counter position
  always_comb begin
    st0_d    = SYNC_IDLE;
    hs_on    = (h_q >= CW'(H_SYNC_START)) && (h_q < CW'(H_SYNC_END));
    vs_on    = (v_q >= CW'(V_SYNC_START)) && (v_q < CW'(V_SYNC_END));
    st0_d.hs = hs_on ? H_POL : ~H_POL;
    st0_d.vs = vs_on ? V_POL : ~V_POL;
    st0_d.de = (h_q < CW'(H_ACTIVE)) && (v_q < CW'(V_ACTIVE));
    st0_d.ls = (h_q == '0);
    st0_d.fs = (h_q == '0) && (v_q == '0);
  end

  // pipe_q[0] is stage 0; pipe_q[SYNC_DELAY] drives the sync outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      h_q    <= '0;
      v_q    <= '0;
      fcnt_q <= '0;
      x_q    <= '0;
      y_q    <= '0;
      for (int i = 0; i <= int'(SYNC_DELAY); i++) begin
        pipe_q[i] <= SYNC_IDLE;
      end
    end else if (pix_en) begin
      h_q       <= h_d;
      v_q       <= v_d;
      fcnt_q    <= fcnt_d;
      x_q       <= h_q;
      y_q       <= v_q;
      pipe_q[0] <= st0_d;
      for (int i = 1; i <= int'(SYNC_DELAY); i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign frame_cnt   = fcnt_q;
  assign hs          = pipe_q[SYNC_DELAY].hs;
  assign vs          = pipe_q[SYNC_DELAY].vs;
  assign de          = pipe_q[SYNC_DELAY].de;
  assign line_start  = pipe_q[SYNC_DELAY].ls;
  assign frame_start = pipe_q[SYNC_DELAY].fs;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: small geometries with zero and three-stage
// sync delay, inverted polarity, 2-bit frame counter, and one default-geometry line.
module tb_vga_timing_gen;

  logic       clk = 1'b0;
  logic [2:0] rst;
  logic [2:0] en;

  logic [9:0] x0, y0, x1, y1, x2, y2;
  logic       hs0, vs0, de0, ls0, fs0;
  logic       hs1, vs1, de1, ls1, fs1;
  logic       hs2, vs2, de2, ls2, fs2;
  logic [7:0] fc0, fc2;
  logic [1:0] fc1;

  int applied     = 0;
  int miscompares = 0;
  int cur [3];

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(1'b0), .V_POL(1'b0), .CW(10), .SYNC_DELAY(0), .FCW(8)
  ) u0 (
    .clk(clk), .reset(rst[0]), .pix_en(en[0]), .x(x0), .y(y0),
    .hs(hs0), .vs(vs0), .de(de0), .line_start(ls0), .frame_start(fs0), .frame_cnt(fc0)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(1'b1), .V_POL(1'b1), .CW(10), .SYNC_DELAY(3), .FCW(2)
  ) u1 (
    .clk(clk), .reset(rst[1]), .pix_en(en[1]), .x(x1), .y(y1),
    .hs(hs1), .vs(vs1), .de(de1), .line_start(ls1), .frame_start(fs1), .frame_cnt(fc1)
  );

  vga_timing_gen u2 (
    .clk(clk), .reset(rst[2]), .pix_en(en[2]), .x(x2), .y(y2),
    .hs(hs2), .vs(vs2), .de(de2), .line_start(ls2), .frame_start(fs2), .frame_cnt(fc2)
  );

  typedef struct {
    int sel;  // which DUT
    int tick; // cumulative pix_en ticks since reset release
    int x, y, hs, vs, de, ls, fs, fc;
  } vec_t;

  vec_t vecs [$];

  task automatic chk(input string nm, input int act, input int exp);
    applied++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Starts and ends at a negedge; each tick is one posedge with pix_en high.
  task automatic run(input int sel, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      en[sel] = 1'b1;
      @(negedge clk);
      en[sel] = 1'b0;
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic get(input int sel, output int ox, output int oy, output int ohs,
                     output int ovs, output int ode, output int ols, output int ofs,
                     output int ofc);
    case (sel)
      0: begin ox = int'(x0); oy = int'(y0); ohs = int'(hs0); ovs = int'(vs0);
               ode = int'(de0); ols = int'(ls0); ofs = int'(fs0); ofc = int'(fc0); end
      1: begin ox = int'(x1); oy = int'(y1); ohs = int'(hs1); ovs = int'(vs1);
               ode = int'(de1); ols = int'(ls1); ofs = int'(fs1); ofc = int'(fc1); end
      default: begin ox = int'(x2); oy = int'(y2); ohs = int'(hs2); ovs = int'(vs2);
               ode = int'(de2); ols = int'(ls2); ofs = int'(fs2); ofc = int'(fc2); end
    endcase
  endtask

  task automatic chk_all(input string tag, input vec_t v);
    int ax, ay, ahs, avs, ade, als, afs, afc;
    get(v.sel, ax, ay, ahs, avs, ade, als, afs, afc);
    chk({tag, ".x"},  ax,  v.x);
    chk({tag, ".y"},  ay,  v.y);
    chk({tag, ".hs"}, ahs, v.hs);
    chk({tag, ".vs"}, avs, v.vs);
    chk({tag, ".de"}, ade, v.de);
    chk({tag, ".ls"}, als, v.ls);
    chk({tag, ".fs"}, afs, v.fs);
    chk({tag, ".fc"}, afc, v.fc);
  endtask

  // Reset with pix_en also high, to show reset takes priority.
  task automatic pulse_reset(input int sel);
    rst[sel] = 1'b1;
    en[sel]  = 1'b1;
    @(negedge clk);
    rst[sel] = 1'b0;
    en[sel]  = 1'b0;
    cur[sel] = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not complete within time limit");
    $fatal(1);
  end

  initial begin
    int ax, ay, ahs, avs, ade, als, afs, afc;
    int de_cnt, hsl_cnt, ls_cnt, fs_cnt, vsl_cnt;

    //            sel tick  x  y hs vs de ls fs fc
    vecs.push_back('{0,   0,  0, 0, 1, 1, 0, 0, 0, 0});
    vecs.push_back('{0,   1,  0, 0, 1, 1, 1, 1, 1, 0});
    vecs.push_back('{0,   2,  1, 0, 1, 1, 1, 0, 0, 0});
    vecs.push_back('{0,   8,  7, 0, 1, 1, 1, 0, 0, 0});
    vecs.push_back('{0,   9,  8, 0, 1, 1, 0, 0, 0, 0});
    vecs.push_back('{0,  11, 10, 0, 0, 1, 0, 0, 0, 0});
    vecs.push_back('{0,  12, 11, 0, 0, 1, 0, 0, 0, 0});
    vecs.push_back('{0,  13, 12, 0, 1, 1, 0, 0, 0, 0});
    vecs.push_back('{0,  14, 13, 0, 1, 1, 0, 0, 0, 0});
    vecs.push_back('{0,  15,  0, 1, 1, 1, 1, 1, 0, 0});
    vecs.push_back('{0,  57,  0, 4, 1, 1, 0, 1, 0, 0});
    vecs.push_back('{0,  71,  0, 5, 1, 0, 0, 1, 0, 0});
    vecs.push_back('{0,  81, 10, 5, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{0,  83, 12, 5, 1, 0, 0, 0, 0, 0});
    vecs.push_back('{0,  85,  0, 6, 1, 1, 0, 1, 0, 0});
    vecs.push_back('{0,  97, 12, 6, 1, 1, 0, 0, 0, 0});
    vecs.push_back('{0,  98, 13, 6, 1, 1, 0, 0, 0, 1});
    vecs.push_back('{0,  99,  0, 0, 1, 1, 1, 1, 1, 1});
    vecs.push_back('{0, 197,  0, 0, 1, 1, 1, 1, 1, 2});
    // Three-stage delay, active-high syncs, pix_en every 4th clk
    vecs.push_back('{1,   0,  0, 0, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{1,   1,  0, 0, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{1,   3,  2, 0, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{1,   4,  3, 0, 0, 0, 1, 1, 1, 0});
    vecs.push_back('{1,   5,  4, 0, 0, 0, 1, 0, 0, 0});
    vecs.push_back('{1,  11, 10, 0, 0, 0, 1, 0, 0, 0});
    vecs.push_back('{1,  12, 11, 0, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{1,  14, 13, 0, 1, 0, 0, 0, 0, 0});
    vecs.push_back('{1,  15,  0, 1, 1, 0, 0, 0, 0, 0});
    vecs.push_back('{1,  16,  1, 1, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{1,  17,  2, 1, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{1,  18,  3, 1, 0, 0, 1, 1, 0, 0});
    vecs.push_back('{1,  74,  3, 5, 0, 1, 0, 1, 0, 0});
    vecs.push_back('{1,  88,  3, 6, 0, 0, 0, 1, 0, 0});
    vecs.push_back('{1,  98, 13, 6, 1, 0, 0, 0, 0, 1});
    vecs.push_back('{1, 102,  3, 0, 0, 0, 1, 1, 1, 1});

    rst = 3'b111;
    en  = 3'b000;
    repeat (3) @(negedge clk);
    rst = 3'b000;
    foreach (cur[i]) cur[i] = 0;

    foreach (vecs[i]) begin
      run(vecs[i].sel, vecs[i].tick - cur[vecs[i].sel], (vecs[i].sel == 1) ? 3 : 0);
      cur[vecs[i].sel] = vecs[i].tick;
      chk_all($sformatf("vec%0d", i), vecs[i]);
    end

    // Hold while pix_en stays low
    repeat (5) @(negedge clk);
    get(1, ax, ay, ahs, avs, ade, als, afs, afc);
    chk("hold.x", ax, 3);
    chk("hold.fs", afs, 1);
    chk("hold.fc", afc, 1);

    // 2-bit frame counter across successive frame wraps
    run(1, 195 - cur[1], 3); cur[1] = 195;
    get(1, ax, ay, ahs, avs, ade, als, afs, afc); chk("fcw.195", afc, 1);
    run(1, 1, 3); cur[1] = 196;
    get(1, ax, ay, ahs, avs, ade, als, afs, afc); chk("fcw.196", afc, 2);
    run(1, 98, 3); cur[1] = 294;
    get(1, ax, ay, ahs, avs, ade, als, afs, afc); chk("fcw.294", afc, 3);
    run(1, 98, 3); cur[1] = 392;
    get(1, ax, ay, ahs, avs, ade, als, afs, afc); chk("fcw.392", afc, 0);
    run(1, 98, 3); cur[1] = 490;
    chk_all("fcw.490", '{1, 490, 13, 6, 1, 0, 0, 0, 0, 1});

    // Reset during active sync pulse: straight to inactive, no glitch
    pulse_reset(1);
    chk_all("rst1", '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    for (int k = 1; k <= 4; k++) begin
      run(1, 1, 3);
      get(1, ax, ay, ahs, avs, ade, als, afs, afc);
      chk($sformatf("rst1.fs.k%0d", k), afs, (k == 4) ? 1 : 0);
    end
    chk("rst1.x.k4", ax, 3);

    // Reset mid-active-line on the zero-delay instance
    run(0, 230 - cur[0], 0); cur[0] = 230;
    chk_all("mid0", '{0, 230, 5, 2, 1, 1, 1, 0, 0, 2});
    pulse_reset(0);
    chk_all("rst0", '{0, 0, 0, 0, 1, 1, 0, 0, 0, 0});
    run(0, 1, 0);
    chk_all("rst0.k1", '{0, 1, 0, 0, 1, 1, 1, 1, 1, 0});

    // Default 640x480 geometry, pix_en every 4th clk, first line plus one tick
    chk_all("dflt.rst", '{2, 0, 0, 0, 1, 1, 0, 0, 0, 0});
    de_cnt = 0; hsl_cnt = 0; ls_cnt = 0; fs_cnt = 0; vsl_cnt = 0;
    for (int k = 0; k < 801; k++) begin
      run(2, 1, 3);
      de_cnt  += int'(de2);
      hsl_cnt += int'(!hs2);
      vsl_cnt += int'(!vs2);
      ls_cnt  += int'(ls2);
      fs_cnt  += int'(fs2);
    end
    chk("dflt.de_ticks", de_cnt, 640);
    chk("dflt.hs_low_ticks", hsl_cnt, 96);
    chk("dflt.vs_low_ticks", vsl_cnt, 0);
    chk("dflt.ls_ticks", ls_cnt, 1);
    chk("dflt.fs_ticks", fs_cnt, 1);
    chk("dflt.x", int'(x2), 0);
    chk("dflt.y", int'(y2), 1);
    chk("dflt.fc", int'(fc2), 0);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA raster timing generator; next generation of the team's fixed 640x480 sync generator.
- Adds:
  - configurable active/porch/sync geometry and sync polarity
  - pixel-clock enable, so a fast system clock can drive a slower pixel rate
  - a configurable sync/blank delay line that aligns HS/VS/DE with an external pixel-fetch pipeline
  - line/frame strobes and a frame counter
- Sits between the system clock domain and the VGA DAC/pins; its x/y drive the framebuffer read address.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- H_POL, 0, HS active level (0 = active-low)
- V_POL, 0, VS active level (0 = active-low)
- CW, 10, x/y counter width; must hold H_TOTAL-1 and V_TOTAL-1
- SYNC_DELAY, 2, extra pix_en-qualified stages applied to hs/vs/de/strobes relative to x/y (0 allowed)
- FCW, 8, frame counter width

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- pix_en  in  1  pixel tick; all state advances only when high
- x  out  CW  current horizontal counter (raw, 0..H_TOTAL-1)
- y  out  CW  current vertical counter (raw, 0..V_TOTAL-1)
- hs  out  1  horizontal sync, polarity per H_POL, delayed
- vs  out  1  vertical sync, polarity per V_POL, delayed
- de  out  1  display enable (active region), delayed
- line_start  out  1  one-pix_en pulse at h=0, delayed
- frame_start  out  1  one-pix_en pulse at h=0,v=0, delayed
- frame_cnt  out  FCW  completed frames, wraps modulo 2^FCW

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Line order is active, front porch, sync, back porch; the frame uses the same order.
- Counters h, v:
  - On a clk edge with pix_en=1, h increments.
  - At h==H_TOTAL-1, h wraps to 0 and v increments.
  - At v==V_TOTAL-1 with h wrap, v wraps to 0 and frame_cnt increments (mod 2^FCW).
  - pix_en=0: all state and outputs hold, including the delay line.
- Stage 0 (registered, 1 pix_en latency from counter):
  - x = h and y = v.
  - de0 = (h<H_ACTIVE)&&(v<V_ACTIVE).
  - hs0 = H_POL when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC, else ~H_POL.
  - vs0 = V_POL when V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC, else ~V_POL. vs0 is a function of v only and changes at the line boundary.
  - ls0 = (h==0); fs0 = (h==0&&v==0).
- Delay line: hs/vs/de/line_start/frame_start equal stage-0 values after SYNC_DELAY further pix_en-qualified stages. With SYNC_DELAY=0 they are stage-0 registers directly. x/y are never delayed.
- Strobes are high for exactly one pix_en period; they are not gated to a single clk if pix_en is held high continuously.
- Reset (synchronous, priority over pix_en):
  - h=v=0; x=y=0.
  - de=0, line_start=0, frame_start=0, frame_cnt=0.
  - hs=~H_POL, vs=~V_POL; every delay-line stage is cleared to these inactive values.
  - The first pix_en after reset produces stage-0 for h=0,v=0, so frame_start appears SYNC_DELAY+1 pix_en ticks after reset release.
- Reset mid-frame: abandon the frame immediately. No sync or de glitch: outputs go straight to inactive values the cycle after reset is sampled.
- frame_cnt increments on the wrap edge itself; it is not delayed and does not depend on SYNC_DELAY.
- Degenerate parameters are unsupported: any porch or sync of 0, or CW too small. Assert them at elaboration.

Test Plan:
- Small geometry (H 8/2/2/2, V 4/1/1/1, SYNC_DELAY=0, pix_en=1):
  - x cycles 0..13; hs low exactly when x∈{10,11} (aligned same cycle).
  - de high for x<8,y<4.
  - vs low for y==5.
  - frame_start every 14*7=98 cycles.
- pix_en high every 4th clk (default 640x480):
  - one line = 3200 clks; one frame = 3200*525 clks.
  - de high for 640 ticks per active line.
  - frame_cnt increments each frame; holds when pix_en low.
- SYNC_DELAY=3:
  - de rises exactly 3 pix_en ticks after x steps to 0 on an active line; hs/vs offset by 3 ticks likewise.
  - x/y unchanged versus SYNC_DELAY=0.
- H_POL=1, V_POL=1:
  - hs high only during sync; idle low after reset.
  - vs mirrors hs behaviour.
- Reset asserted mid-active-line (x=300,y=200):
  - next cycle x=y=0, de=0, hs/vs inactive, frame_cnt=0.
  - after release, frame_start appears after SYNC_DELAY+1 ticks.
- FCW=2:
  - run 5 frames; frame_cnt sequence 1,2,3,0,1 at successive frame wraps.
